// File: rtl/rice_core_csr_master.sv
// Zicsr execute-stage engine: turns one CSR instruction into a non-posted read
// and an optional non-posted write on the 12-bit CSR bus.
module rice_core_csr_master #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_privilege_level,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [11:0]       i_address,
  input  logic [1:0]        i_operation,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_read_enable,
  input  logic              i_write_enable,
  output logic              o_done,
  output logic [XLEN-1:0]   o_read_data,
  output logic              o_illegal,
  output logic              o_request_valid,
  input  logic              i_request_ready,
  output logic [11:0]       o_address,
  output logic              o_write,
  output logic [XLEN-1:0]   o_write_data,
  output logic [XLEN/8-1:0] o_strobe,
  input  logic              i_response_valid,
  output logic              o_response_ready,
  input  logic [XLEN-1:0]   i_read_data,
  input  logic              i_error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [1:0] OP_RW = 2'd1;
  localparam logic [1:0] OP_RS = 2'd2;
  localparam logic [1:0] OP_RC = 2'd3;

  logic [2:0]      state;
  logic [11:0]     addr_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] operand_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            wen_q;
  logic            illegal_q;
  logic            discard_q;

  logic            accept;
  logic            precheck_bad;
  logic [XLEN-1:0] merged;

  assign accept = (state == IDLE) && i_valid && !i_flush;

  // Privilege field of the address vs. current mode, writes to the read-only
  // quadrant, and the reserved operation encoding are all rejected up front.
  assign precheck_bad = (i_address[9:8] > i_privilege_level) ||
                        ((i_address[11:10] == 2'b11) && i_write_enable) ||
                        (i_operation == 2'd0);

  always_comb begin
    merged = operand_q;
    case (op_q)
      OP_RW:   merged = operand_q;
      OP_RS:   merged = i_read_data | operand_q;
      OP_RC:   merged = i_read_data & ~operand_q;
      default: merged = operand_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      operand_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= i_address;
            op_q      <= i_operation;
            operand_q <= i_operand;
            wdata_q   <= i_operand;
            wen_q     <= i_write_enable;
            rdata_q   <= '0;
            discard_q <= 1'b0;
            illegal_q <= precheck_bad;
            if (precheck_bad)
              state <= DONE;
            else if (i_read_enable || i_operation[1])
              state <= RD_REQ;
            else
              state <= WR_REQ;
          end
        end
        RD_REQ: begin
          // A flushed request that still handshakes this cycle owes a response.
          if (i_flush) begin
            discard_q <= 1'b1;
            state     <= i_request_ready ? RD_RESP : IDLE;
          end else if (i_request_ready) begin
            state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (i_response_valid) begin
            if (discard_q || i_flush) begin
              state <= IDLE;
            end else if (i_error) begin
              illegal_q <= 1'b1;
              rdata_q   <= '0;
              state     <= DONE;
            end else begin
              rdata_q <= i_read_data;
              wdata_q <= merged;
              state   <= wen_q ? WR_REQ : DONE;
            end
          end else if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        WR_REQ: begin
          if (i_flush) begin
            discard_q <= 1'b1;
            state     <= i_request_ready ? WR_RESP : IDLE;
          end else if (i_request_ready) begin
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (i_response_valid) begin
            if (discard_q || i_flush) begin
              state <= IDLE;
            end else begin
              if (i_error) begin
                illegal_q <= 1'b1;
                rdata_q   <= '0;
              end
              state <= DONE;
            end
          end else if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready          = (state == IDLE);
  assign o_done           = (state == DONE) && !i_flush;
  assign o_read_data      = rdata_q;
  assign o_illegal        = illegal_q;
  assign o_request_valid  = (state == RD_REQ) || (state == WR_REQ);
  assign o_write          = (state == WR_REQ);
  assign o_address        = addr_q;
  assign o_write_data     = wdata_q;
  assign o_strobe         = {(XLEN/8){state == WR_REQ}};
  assign o_response_ready = (state == RD_RESP) || (state == WR_RESP);

endmodule
